// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int          SRAM_AW         = 20;
    localparam int          WAIT_W          = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces SRAM wait states.
// It stops at zero and flags the decrement that reaches zero.
module mem_wait_counter #(
    parameter int WAIT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o,
    output logic              last_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
    // Asserted on the edge whose decrement lands on zero.
    assign last_o = dec_i && !load_i && (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/mem_io_responder.sv
// Memory responder for the SLC-3 MAR/MDR interface.
// It serves SRAM with wait states or the switch/hex I/O register, and answers with R.
module mem_io_responder
    import slc3_mem_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               MIO_EN,
    input  logic               WE,
    input  logic [15:0]        MAR,
    input  logic [15:0]        MDR,
    input  logic [15:0]        SW,
    output logic [15:0]        Data_to_CPU,
    output logic               R,
    output logic [15:0]        HEX_Out,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_Out,
    input  logic [15:0]        SRAM_DQ_In,
    output logic               SRAM_DQ_OE,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_STATES);

    state_e             state_q;
    logic               r_q, we_q;
    logic [15:0]        data_q, hex_q, dq_out_q;
    logic [SRAM_AW-1:0] addr_q;
    logic               dq_oe_q, ce_n_q, oe_n_q, we_n_q;

    logic io_hit, cnt_load, cnt_zero, cnt_last;

    assign io_hit   = (MAR == IO_ADDR);
    assign cnt_load = (state_q == IDLE) && MIO_EN && !io_hit;

    mem_wait_counter #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_LD),
        .dec_i      (state_q == ACCESS),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            r_q      <= 1'b0;
            we_q     <= 1'b0;
            data_q   <= '0;
            hex_q    <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MIO_EN) begin
                        addr_q   <= {{(SRAM_AW-16){1'b0}}, MAR};
                        dq_out_q <= MDR;
                        we_q     <= WE;
                        if (io_hit) begin
                            if (WE) hex_q  <= MDR;
                            else    data_q <= SW;
                            r_q     <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= WE;
                            we_n_q  <= !WE;
                            dq_oe_q <= WE;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // WE_N releases one cycle early so address/data hold past the strobe.
                    if (!cnt_zero) begin
                        if (cnt_last && we_q) we_n_q <= 1'b1;
                    end else begin
                        if (!we_q) data_q <= SRAM_DQ_In;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        r_q     <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!MIO_EN) begin
                        r_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Data_to_CPU = data_q;
    assign R           = r_q;
    assign HEX_Out     = hex_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_Out = dq_out_q;
    assign SRAM_DQ_OE  = dq_oe_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder with a behavioural SRAM and reference memory.
module tb_mem_io_responder;

    localparam int W = 2;

    logic        Clk = 1'b0, Reset = 1'b1, MIO_EN = 1'b0, WE = 1'b0;
    logic [15:0] MAR = '0, MDR = '0, SW = '0;
    logic [15:0] Data_to_CPU, HEX_Out, SRAM_DQ_Out, SRAM_DQ_In;
    logic [19:0] SRAM_ADDR;
    logic        R, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

    mem_io_responder #(.WAIT_STATES(W), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .WE(WE), .MAR(MAR), .MDR(MDR), .SW(SW),
        .Data_to_CPU(Data_to_CPU), .R(R), .HEX_Out(HEX_Out), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_Out(SRAM_DQ_Out), .SRAM_DQ_In(SRAM_DQ_In), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM: 256 words aliased on the low address byte, written as WE_N releases.
    logic [15:0] sram [256];
    assign SRAM_DQ_In = sram[SRAM_ADDR[7:0]];
    always @(posedge SRAM_WE_N)
        if (!Reset && !SRAM_CE_N) sram[SRAM_ADDR[7:0]] = SRAM_DQ_Out;

    logic [15:0] ref_mem [256];
    logic [15:0] last_rd = '0, hex_m = '0;

    typedef struct {
        int          lat, ce, we_n, oe_n, dq, rlen;
        logic [15:0] data, hex, mdr;
        logic [19:0] addr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: negedges are counted from issue, so one precedes the sampling edge.
    int lat = 0, ce_c = 0, wen_c = 0, oen_c = 0, dq_c = 0, rl = 0;
    bit got_r = 0;
    always @(negedge Clk) begin
        if (!Reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q[0];
            if (!got_r) begin
                lat++;
                if (!SRAM_CE_N) begin ce_c++; chk("sram_addr", SRAM_ADDR, e.addr); end
                if (!SRAM_WE_N) wen_c++;
                if (!SRAM_OE_N) oen_c++;
                if (SRAM_DQ_OE) begin dq_c++; chk("dq_out", SRAM_DQ_Out, e.mdr); end
                if (R) begin
                    got_r = 1; rl = 1;
                    chk("latency", lat, e.lat);
                    chk("data_to_cpu", Data_to_CPU, e.data);
                    chk("hex_out", HEX_Out, e.hex);
                    chk("ce_n_cycles", ce_c, e.ce);
                    chk("we_n_cycles", wen_c, e.we_n);
                    chk("oe_n_cycles", oen_c, e.oe_n);
                    chk("dq_oe_cycles", dq_c, e.dq);
                end
            end else if (R) begin
                rl++;
            end else begin
                chk("r_high_cycles", rl, e.rlen);
                void'(exp_q.pop_front());
                got_r = 0; lat = 0; ce_c = 0; wen_c = 0; oen_c = 0; dq_c = 0;
            end
        end
    end

    task automatic wait_r(input logic v, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (R === v) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL r_timeout: R never reached %0d", v);
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] mar, mdr, sw,
                         input int hold, input bit early);
        exp_t e;
        bit   io, ok;
        io = (mar == 16'hFFFF);
        if (!we) last_rd = io ? sw : ref_mem[mar[7:0]];
        else if (io) hex_m = mdr;
        else ref_mem[mar[7:0]] = mdr;
        e.lat  = io ? 2 : W + 3;
        e.ce   = io ? 0 : W + 1;
        e.we_n = (!io && we) ? W : 0;
        e.oe_n = (!io && !we) ? W + 1 : 0;
        e.dq   = (!io && we) ? W + 1 : 0;
        e.rlen = early ? 1 : hold + 1;
        e.data = last_rd;
        e.hex  = hex_m;
        e.mdr  = mdr;
        e.addr = {4'h0, mar};
        @(posedge Clk); #1;
        MIO_EN = 1; WE = we; MAR = mar; MDR = mdr; SW = sw;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        // Inputs after the sampling edge must be ignored.
        WE = 1'($urandom); MAR = 16'($urandom); MDR = 16'($urandom); SW = 16'($urandom);
        if (early) MIO_EN = 0;
        wait_r(1'b1, ok);
        if (!ok) return;
        if (!early) begin
            repeat (hold) @(posedge Clk);
            if (hold > 0) #1;
            MIO_EN = 0;
        end
        wait_r(1'b0, ok);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            sram[i] = v;
            ref_mem[i] = v;
        end
        sram[8'h00] = 16'hBEEF;
        ref_mem[8'h00] = 16'hBEEF;

        @(negedge Clk);
        chk("rst_r", R, 0);
        chk("rst_data", Data_to_CPU, 0);
        chk("rst_hex", HEX_Out, 0);
        chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("rst_dq_oe", SRAM_DQ_OE, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dq_out", SRAM_DQ_Out, 0);
        @(posedge Clk); #1 Reset = 0;

        issue(1'b0, 16'h3000, 16'h0000, 16'h1357, 2, 1'b0);
        issue(1'b1, 16'h1234, 16'hA5A5, 16'h0000, 1, 1'b0);
        issue(1'b0, 16'hFFFF, 16'h0000, 16'h00F0, 0, 1'b0);
        issue(1'b1, 16'hFFFF, 16'h0042, 16'h0000, 1, 1'b0);
        issue(1'b0, 16'h2222, 16'h0000, 16'h0000, 0, 1'b1);
        issue(1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            bit          io;
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            io = (a == 16'hFFFF);
            issue(1'($urandom), a, 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 2)), !io && ($urandom_range(0, 3) == 0));
        end

        // Reset asserted mid-write must clear everything before the next edge.
        @(posedge Clk); #1;
        MIO_EN = 1; WE = 1; MAR = 16'h0456; MDR = 16'h1111;
        @(posedge Clk); #1;
        chk("pre_rst_we_n", SRAM_WE_N, 0);
        @(posedge Clk); #2;
        Reset = 1;
        #1;
        chk("async_rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 3'b111);
        chk("async_rst_dq_oe", SRAM_DQ_OE, 0);
        chk("async_rst_r", R, 0);
        chk("async_rst_hex", HEX_Out, 0);
        chk("async_rst_data", Data_to_CPU, 0);
        chk("async_rst_addr", SRAM_ADDR, 0);
        MIO_EN = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 0;
        last_rd = '0;
        hex_m   = '0;

        issue(1'b0, 16'h0456, 16'h0000, 16'h0000, 1, 1'b0);
        issue(1'b0, 16'hFFFF, 16'h0000, 16'hC0DE, 0, 1'b0);

        repeat (3) @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
